// File: rtl/icache.sv
//==============================================================================
// Module      : icache
// Description : Direct-mapped, one-word-per-line instruction cache with a
//               zero-latency hit path and a single outstanding refill.
//               Optional hit/miss statistics counters are compiled in when
//               the macro ICACHE_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module icache #(
   parameter int LINES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   input  logic        flush,
   output logic [31:0] instr,
   output logic        stall_req,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   // Index width and remaining tag width of a 30-bit word address.
   localparam int c_IB = $clog2(LINES);
   localparam int c_TW = 30 - c_IB;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_FETCH = 1'b1
   } state_t;

   state_t            r_state;
   logic [LINES-1:0]  r_valid;
   logic [c_TW-1:0]   r_tag  [LINES];
   logic [31:0]       r_data [LINES];
   logic [29:0]       r_missWord;
   logic              r_memReq;
   logic [31:0]       r_memAddr;

   logic [c_IB-1:0]   w_idx;
   logic [c_TW-1:0]   w_tag;
   logic [c_IB-1:0]   w_missIdx;
   logic [c_TW-1:0]   w_missTag;
   logic              w_hit;
   logic              w_missStart;
   logic              w_fill;
   logic              w_unusedPcLsb;

   // Byte offset within the word never selects anything.
   assign w_unusedPcLsb = ^pcF[1:0];

   assign w_idx     = pcF[c_IB+1:2];
   assign w_tag     = pcF[31:c_IB+2];
   assign w_missIdx = r_missWord[c_IB-1:0];
   assign w_missTag = r_missWord[29:c_IB];

   // A flush in progress hides every line, so it also suppresses a hit.
   assign w_hit = (r_state == S_IDLE) && !flush && r_valid[w_idx]
                  && (r_tag[w_idx] == w_tag);

   // Miss in IDLE starts a refill unless the cache is being flushed.
   assign w_missStart = (r_state == S_IDLE) && !w_hit && !flush;

   // Refill completion writes the line; reset abandons the transaction.
   assign w_fill = (r_state == S_FETCH) && mem_ack && !rst;

   assign instr     = w_hit ? r_data[w_idx] : 32'h0;
   assign stall_req = !w_hit;
   assign mem_req   = r_memReq;
   assign mem_addr  = r_memAddr;

   // Controller: state, miss address, bus outputs and valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_missWord <= '0;
         r_memReq   <= 1'b0;
         r_memAddr  <= 32'h0;
      end else begin
         if (flush) begin
            r_valid <= '0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_missStart) begin
                  r_state    <= S_FETCH;
                  r_missWord <= pcF[31:2];
                  r_memReq   <= 1'b1;
                  r_memAddr  <= {pcF[31:2], 2'b00};
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  r_state   <= S_IDLE;
                  r_memReq  <= 1'b0;
                  r_memAddr <= 32'h0;
                  // Later assignment wins over the flush clear above, so a
                  // coincident flush leaves the refilled line invalid.
                  r_valid[w_missIdx] <= !flush;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_memReq  <= 1'b0;
               r_memAddr <= 32'h0;
            end
         endcase
      end
   end

   // Tag and data storage; contents are qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_missIdx]  <= w_missTag;
         r_data[w_missIdx] <= mem_rdata;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hitCnt;
   logic [31:0] r_missCnt;

   assign hit_cnt  = r_hitCnt;
   assign miss_cnt = r_missCnt;

   // Saturating hit and miss statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hitCnt  <= 32'h0;
         r_missCnt <= 32'h0;
      end else begin
         if (w_hit && (r_hitCnt != 32'hFFFF_FFFF)) begin
            r_hitCnt <= r_hitCnt + 32'd1;
         end
         if (w_missStart && (r_missCnt != 32'hFFFF_FFFF)) begin
            r_missCnt <= r_missCnt + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The parameter list SHALL be: LINES, default 16, number of one-word lines (power of two, 2..256).
REQ-002 The clock port SHALL be: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The reset port SHALL be: rst, input, 1; reset is synchronous and active-high.
REQ-004 The PC input SHALL be: pcF, input, 32, fetch address from the datapath IF stage.
REQ-005 The invalidate input SHALL be: flush, input, 1, invalidates all lines.
REQ-006 The instruction output SHALL be: instr, output, 32, word delivered to the datapath.
REQ-007 The stall output SHALL be: stall_req, output, 1, to the hazard unit, which ORs it into stallF/stallD.
REQ-008 The bus request SHALL be: mem_req, output, 1, refill request to instruction memory.
REQ-009 The bus address SHALL be: mem_addr, output, 32, word-aligned refill address.
REQ-010 The bus data input SHALL be: mem_rdata, input, 32, refill data, valid when mem_ack=1.
REQ-011 The bus acknowledge SHALL be: mem_ack, input, 1, one-cycle completion strobe.

Function
REQ-012 Address fields SHALL be idx = pcF[IB+1:2] and tag = pcF[31:IB+2], with IB = log2(LINES); pcF[1:0] SHALL be ignored.
REQ-013 Storage SHALL be, per line, a valid bit, a tag and a 32-bit data word.
REQ-014 hit SHALL be combinational: state==IDLE and valid[idx] and tag[idx]==tag.
REQ-015 On hit, instr SHALL equal data[idx] in the same cycle (zero-latency), with stall_req=0.
REQ-016 When not hit, instr SHALL be 32'h0.
REQ-017 stall_req SHALL be 1 whenever hit=0, including every FETCH cycle and the IDLE miss cycle.
REQ-018 The FSM SHALL have two states: IDLE and FETCH.
REQ-019 The IDLE->FETCH transition SHALL occur on a miss with flush=0, latching miss_addr = {pcF[31:2],2'b00}.
REQ-020 FETCH SHALL hold mem_req=1 and mem_addr=miss_addr stable until mem_ack.
REQ-021 In FETCH, on mem_ack the line at miss_addr's index SHALL be written (data=mem_rdata, tag, valid=1) and the FSM SHALL return to IDLE.
REQ-022 The cycle after a refill SHALL hit on the same pcF; miss-to-hit latency SHALL be (cycles to mem_ack) + 2.
REQ-023 mem_req SHALL be 0 in IDLE; mem_addr SHALL be 32'h0 in IDLE.
REQ-024 flush=1 SHALL clear all valid bits at the next edge; flush in IDLE SHALL force hit=0 that cycle and SHALL NOT start a fetch.
REQ-025 flush during FETCH SHALL NOT abort the bus transaction; on mem_ack the line SHALL be written with valid=0, or with valid=1 if flush is already deasserted by that cycle.
REQ-026 flush coincident with mem_ack SHALL leave the refilled line invalid.
REQ-027 mem_ack seen in IDLE SHALL be ignored.
REQ-028 pcF changing during FETCH SHALL NOT affect the refill; the refill SHALL use miss_addr.

Reset
REQ-029 rst SHALL take priority over all inputs.
REQ-030 rst SHALL set state=IDLE, clear all valid bits, clear miss_addr, set mem_req=0 and mem_addr=0.
REQ-031 Immediately after reset, outputs SHALL be instr=0 and stall_req=1, since all lines are invalid.
REQ-032 rst during FETCH SHALL abandon the transaction, and a late mem_ack SHALL be ignored.
REQ-033 Tag and data arrays SHALL need no reset.

Configuration
REQ-034 With macro ICACHE_STATS_EN defined, ports hit_cnt[31:0] and miss_cnt[31:0] SHALL exist.
REQ-035 hit_cnt SHALL increment on each cycle with hit=1, miss_cnt on each IDLE->FETCH transition; both SHALL saturate at 32'hFFFFFFFF and reset to 0.
REQ-036 Without ICACHE_STATS_EN, those ports and counters SHALL be absent, with behaviour otherwise identical.

Verification
REQ-037 Cold miss: after reset, pcF=0x0000_0040, mem_ack 3 cycles after mem_req with rdata=0x2008_0005 -> mem_addr=0x40, stall_req high 5 cycles, then instr=0x2008_0005 with stall_req=0.
REQ-038 Conflict: LINES=16, fill 0x40, then pcF=0x80 (same idx 0) -> miss with refill, then pcF=0x40 misses again.
REQ-039 Flush: fill 0x40, pulse flush 1 cycle -> next pcF=0x40 gives stall_req=1 and mem_req=1.
REQ-040 Flush at ack: flush asserted in the mem_ack cycle -> FSM returns to IDLE, line invalid, a second refill is issued.
REQ-041 Reset mid-FETCH: rst asserted while mem_req=1, mem_ack one cycle later -> mem_req=0, no line valid, ack ignored.
REQ-042 Stats (ICACHE_STATS_EN): 1 miss then 4 hit cycles -> miss_cnt=1, hit_cnt=4.
